// File: rtl/mouse_cursor_sprite_if.sv
// Pixel-stream, mouse-state and overlay-output bundle between the VGA timing/mouse logic and the cursor renderer.
interface mouse_cursor_sprite_if #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned RGB_W   = 12
);
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic               video_on;
   logic               frame_start;
   logic [COORD_W-1:0] mouse_x;
   logic [COORD_W-1:0] mouse_y;
   logic               mouse_valid;
   logic               btn_left;
   logic               show;
   logic               cur_on;
   logic [RGB_W-1:0]   cur_rgb;

   modport master (
      output pix_x, pix_y, video_on, frame_start,
      output mouse_x, mouse_y, mouse_valid, btn_left, show,
      input  cur_on, cur_rgb
   );

   modport slave (
      input  pix_x, pix_y, video_on, frame_start,
      input  mouse_x, mouse_y, mouse_valid, btn_left, show,
      output cur_on, cur_rgb
   );
endinterface

// File: rtl/mouse_cursor_sprite.sv
// Procedural arrow-cursor overlay: frame-synchronous position/visibility, auto-hide,
// and a two-stage hit-test / bitmap pipeline with registered enable and colour.
module mouse_cursor_sprite #(
   parameter int unsigned     COORD_W     = 10,
   parameter int unsigned     CUR_W       = 8,
   parameter int unsigned     CUR_H       = 11,
   parameter int unsigned     SCALE_LOG2  = 0,
   parameter int unsigned     RGB_W       = 12,
   parameter logic [RGB_W-1:0] FILL_RGB    = 12'hFFF,
   parameter logic [RGB_W-1:0] PRESS_RGB   = 12'hF80,
   parameter logic [RGB_W-1:0] OUTLINE_RGB = 12'h000,
   parameter int unsigned     HIDE_FRAMES = 180
) (
   input logic                  clk,
   input logic                  reset_n,
   mouse_cursor_sprite_if.slave bus
);

   localparam int unsigned DW      = COORD_W + 1;
   localparam int unsigned SPAN_X  = CUR_W << SCALE_LOG2;
   localparam int unsigned SPAN_Y  = CUR_H << SCALE_LOG2;
   localparam int unsigned BW      = 7;
   localparam int unsigned IDLE_W  = (HIDE_FRAMES > 0) ? $clog2(HIDE_FRAMES + 1) : 1;
   localparam bit          HIDE_EN = (HIDE_FRAMES != 0);

   logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic               act_vis_q, act_vis_d;
   logic [DW-1:0]      dx_q, dx_d, dy_q, dy_d;
   logic               in_x_q, in_x_d, in_y_q, in_y_d;
   logic               vid_q, vid_d, btn_q, btn_d;
   logic               cur_on_q, cur_on_d;
   logic [RGB_W-1:0]   cur_rgb_q, cur_rgb_d;
   logic [BW-1:0]      col, row, row_n;
   logic               bit_set, outline;

   // Frame-synchronous position/visibility; a coincident mouse_valid lands in pend only.
   always_comb begin
      pend_x_d  = pend_x_q;
      pend_y_d  = pend_y_q;
      act_x_d   = act_x_q;
      act_y_d   = act_y_q;
      idle_d    = idle_q;
      act_vis_d = act_vis_q;
      if (bus.frame_start) begin
         act_x_d   = pend_x_q;
         act_y_d   = pend_y_q;
         act_vis_d = bus.show && (!HIDE_EN || (idle_q < IDLE_W'(HIDE_FRAMES)));
         if (idle_q < IDLE_W'(HIDE_FRAMES)) idle_d = idle_q + IDLE_W'(1);
      end
      if (bus.mouse_valid) begin
         pend_x_d = bus.mouse_x;
         pend_y_d = bus.mouse_y;
         idle_d   = '0;
      end
   end

   // Stage 1: signed offsets from the hotspot; negative offsets have the top bit set.
   always_comb begin
      dx_d   = {1'b0, bus.pix_x} - {1'b0, act_x_q};
      dy_d   = {1'b0, bus.pix_y} - {1'b0, act_y_q};
      in_x_d = !dx_d[DW-1] && (dx_d < DW'(SPAN_X));
      in_y_d = !dy_d[DW-1] && (dy_d < DW'(SPAN_Y));
      vid_d  = bus.video_on;
      btn_d  = bus.btn_left;
   end

   // Stage 2: arrow bitmap lookup (row width grows then shrinks) and colour select.
   always_comb begin
      col = BW'(dx_q >> SCALE_LOG2);
      row = BW'(dy_q >> SCALE_LOG2);
      if (row < BW'(CUR_W)) begin
         row_n = row + BW'(1);
      end else begin
         row_n = BW'(CUR_H) - row;
         if (row_n > BW'(CUR_W)) row_n = BW'(CUR_W);
      end
      bit_set = (col < row_n);
      outline = (col == BW'(0)) || (col == row_n - BW'(1)) ||
                (row == BW'(0)) || (row == BW'(CUR_H - 1));
      cur_on_d  = vid_q && act_vis_q && in_x_q && in_y_q && bit_set;
      cur_rgb_d = '0;
      if (cur_on_d) cur_rgb_d = outline ? OUTLINE_RGB : (btn_q ? PRESS_RGB : FILL_RGB);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_x_q  <= '0;
         pend_y_q  <= '0;
         act_x_q   <= '0;
         act_y_q   <= '0;
         idle_q    <= '0;
         act_vis_q <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         in_x_q    <= 1'b0;
         in_y_q    <= 1'b0;
         vid_q     <= 1'b0;
         btn_q     <= 1'b0;
         cur_on_q  <= 1'b0;
         cur_rgb_q <= '0;
      end else begin
         pend_x_q  <= pend_x_d;
         pend_y_q  <= pend_y_d;
         act_x_q   <= act_x_d;
         act_y_q   <= act_y_d;
         idle_q    <= idle_d;
         act_vis_q <= act_vis_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         in_x_q    <= in_x_d;
         in_y_q    <= in_y_d;
         vid_q     <= vid_d;
         btn_q     <= btn_d;
         cur_on_q  <= cur_on_d;
         cur_rgb_q <= cur_rgb_d;
      end
   end

   assign bus.cur_on  = cur_on_q;
   assign bus.cur_rgb = cur_rgb_q;

endmodule

// File: tb/tb_mouse_cursor_sprite.sv
// Bench for mouse_cursor_sprite: three instances (default, HIDE_FRAMES=3, SCALE_LOG2=1) share one stimulus stream.
module tb_mouse_cursor_sprite;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] pix_x, pix_y, mouse_x, mouse_y;
   logic       video_on, frame_start, mouse_valid, btn_left, show;

   mouse_cursor_sprite_if #(.COORD_W(10), .RGB_W(12)) if_d ();
   mouse_cursor_sprite_if #(.COORD_W(10), .RGB_W(12)) if_h ();
   mouse_cursor_sprite_if #(.COORD_W(10), .RGB_W(12)) if_s ();

   assign {if_d.pix_x, if_d.pix_y, if_d.video_on, if_d.frame_start, if_d.mouse_x, if_d.mouse_y,
           if_d.mouse_valid, if_d.btn_left, if_d.show} =
          {pix_x, pix_y, video_on, frame_start, mouse_x, mouse_y, mouse_valid, btn_left, show};
   assign {if_h.pix_x, if_h.pix_y, if_h.video_on, if_h.frame_start, if_h.mouse_x, if_h.mouse_y,
           if_h.mouse_valid, if_h.btn_left, if_h.show} =
          {pix_x, pix_y, video_on, frame_start, mouse_x, mouse_y, mouse_valid, btn_left, show};
   assign {if_s.pix_x, if_s.pix_y, if_s.video_on, if_s.frame_start, if_s.mouse_x, if_s.mouse_y,
           if_s.mouse_valid, if_s.btn_left, if_s.show} =
          {pix_x, pix_y, video_on, frame_start, mouse_x, mouse_y, mouse_valid, btn_left, show};

   mouse_cursor_sprite u_def (.clk(clk), .reset_n(reset_n), .bus(if_d));
   mouse_cursor_sprite #(.HIDE_FRAMES(3)) u_hide (.clk(clk), .reset_n(reset_n), .bus(if_h));
   mouse_cursor_sprite #(.SCALE_LOG2(1)) u_scl (.clk(clk), .reset_n(reset_n), .bus(if_s));

   logic       on_v  [3];
   logic [11:0] rgb_v [3];
   assign on_v[0] = if_d.cur_on;  assign rgb_v[0] = if_d.cur_rgb;
   assign on_v[1] = if_h.cur_on;  assign rgb_v[1] = if_h.cur_rgb;
   assign on_v[2] = if_s.cur_on;  assign rgb_v[2] = if_s.cur_rgb;

   always #5 clk = ~clk;

   typedef struct {
      int sel; int x; int y; bit vo; bit btn; bit fs; bit mv; int mx; int my;
      bit chk; logic on; logic [11:0] rgb;
   } px_t;

   typedef struct {
      bit chk; int sel; int x; int y; logic on; logic [11:0] rgb;
      logic got_on; logic [11:0] got_rgb;
   } exp_t;

   exp_t sb[$];
   exp_t done[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic px_t pp(int sel, int x, int y, bit btn, logic on, logic [11:0] rgb);
      px_t p;
      p = '{default: 0};
      p.sel = sel; p.x = x; p.y = y; p.vo = 1'b1; p.btn = btn;
      p.chk = 1'b1; p.on = on; p.rgb = rgb;
      return p;
   endfunction

   function automatic px_t ev(bit fs, bit mv, int mx, int my);
      px_t p;
      p = '{default: 0};
      p.fs = fs; p.mv = mv; p.mx = mx; p.my = my;
      return p;
   endfunction

   // Reference arrow: 8 wide, 11 tall, scaled by 2^scl (instance 2 uses scl=1).
   function automatic px_t pm(int sel, int x, int y, int ax, int ay, bit vis, bit btn);
      px_t p;
      int  scl, dx, dy, c, r, n;
      p   = pp(sel, x, y, btn, 1'b0, 12'h000);
      scl = (sel == 2) ? 1 : 0;
      dx  = x - ax;
      dy  = y - ay;
      if (vis && dx >= 0 && dy >= 0 && dx < (8 << scl) && dy < (11 << scl)) begin
         c = dx >> scl;
         r = dy >> scl;
         n = (r < 8) ? r + 1 : 11 - r;
         if (n > 8) n = 8;
         if (c < n) begin
            p.on  = 1'b1;
            p.rgb = (c == 0 || c == n - 1 || r == 0 || r == 10) ? 12'h000 :
                    (btn ? 12'hF80 : 12'hFFF);
         end
      end
      return p;
   endfunction

   // Drive one cycle, queue its expectation, and capture the output of the pixel two clocks back.
   task automatic apply(input px_t p);
      exp_t e;
      pix_x = 10'(p.x); pix_y = 10'(p.y); video_on = p.vo; btn_left = p.btn;
      frame_start = p.fs; mouse_valid = p.mv; mouse_x = 10'(p.mx); mouse_y = 10'(p.my);
      e = '{chk: p.chk, sel: p.sel, x: p.x, y: p.y, on: p.on, rgb: p.rgb,
            got_on: 1'b0, got_rgb: 12'h000};
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 2) begin
         e = sb.pop_front();
         e.got_on  = on_v[e.sel];
         e.got_rgb = rgb_v[e.sel];
         if (e.chk) done.push_back(e);
      end
   endtask

   task automatic flush();
      apply(ev(1'b0, 1'b0, 0, 0));
      apply(ev(1'b0, 1'b0, 0, 0));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      pix_x = '0; pix_y = '0; video_on = 1'b0; btn_left = 1'b0; frame_start = 1'b0;
      mouse_valid = 1'b0; mouse_x = '0; mouse_y = '0; show = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (on_v[i] !== 1'b0 || rgb_v[i] !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got on=%b rgb=%h, want on=0 rgb=000", i, on_v[i], rgb_v[i]);
         end
      end
      reset_n = 1'b1;
      apply(ev(1'b0, 1'b1, 100, 50));
      for (int i = 0; i < 3; i++) begin
         apply(pp(i, 100, 50, 1'b0, 1'b0, 12'h000));
         apply(pp(i, 0, 0, 1'b0, 1'b0, 12'h000));
      end
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL reset_no_frame dut%0d (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.sel, e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_shape();
      exp_t e;
      px_t  p;
      apply(ev(1'b0, 1'b1, 100, 50));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(0, 100, 50, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 103, 57, 1'b0, 1'b1, 12'hFFF));
      apply(pp(0, 103, 57, 1'b1, 1'b1, 12'hF80));
      apply(pp(0, 108, 57, 1'b0, 1'b0, 12'h000));
      apply(pp(0, 100, 60, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 101, 60, 1'b0, 1'b0, 12'h000));
      p = pp(0, 100, 50, 1'b0, 1'b0, 12'h000);
      p.vo = 1'b0;
      apply(p);
      for (int y = 48; y <= 62; y++)
         for (int x = 98; x <= 110; x++)
            apply(pm(0, x, y, 100, 50, 1'b1, ((x + y) % 2) == 1));
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL shape (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_buffering();
      exp_t e;
      apply(pp(0, 100, 50, 1'b0, 1'b1, 12'h000));
      apply(ev(1'b0, 1'b1, 200, 200));
      apply(pp(0, 100, 50, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 200, 200, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(0, 200, 200, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 100, 50, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b1, 300, 100));
      apply(pp(0, 200, 200, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 300, 100, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(0, 300, 100, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 303, 107, 1'b0, 1'b1, 12'hFFF));
      apply(pp(0, 200, 200, 1'b0, 1'b0, 12'h000));
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL buffering (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_clip();
      exp_t e;
      int   x, y;
      apply(ev(1'b0, 1'b1, 636, 475));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(0, 636, 475, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 636, 479, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 639, 479, 1'b0, 1'b1, 12'hFFF));
      apply(pp(0, 0, 0, 1'b0, 1'b0, 12'h000));
      for (int yi = 0; yi < 13; yi++) begin
         y = (yi < 9) ? 471 + yi : yi - 9;
         for (int xi = 0; xi < 12; xi++) begin
            x = (xi < 8) ? 632 + xi : xi - 8;
            apply(pm(0, x, y, 636, 475, 1'b1, 1'b0));
         end
      end
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL clip (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_scale();
      exp_t e;
      apply(ev(1'b0, 1'b1, 10, 10));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(2, 14, 24, 1'b1, 1'b1, 12'hF80));
      apply(pp(2, 10, 10, 1'b1, 1'b1, 12'h000));
      apply(pp(2, 11, 10, 1'b1, 1'b1, 12'h000));
      apply(pp(2, 10, 11, 1'b1, 1'b1, 12'h000));
      apply(pp(2, 11, 11, 1'b1, 1'b1, 12'h000));
      for (int y = 8; y <= 33; y++)
         for (int x = 8; x <= 27; x++)
            apply(pm(2, x, y, 10, 10, 1'b1, ((x * 3 + y) % 2) == 1));
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL scale (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_hide();
      exp_t e;
      bool_loop: begin end
      do_reset();
      show = 1'b1;
      apply(ev(1'b0, 1'b1, 50, 50));
      for (int f = 1; f <= 5; f++) begin
         apply(ev(1'b1, 1'b0, 0, 0));
         apply(pp(1, 50, 50, 1'b0, f <= 3, 12'h000));
         apply(pp(1, 52, 53, 1'b0, f <= 3, (f <= 3) ? 12'hFFF : 12'h000));
      end
      apply(ev(1'b0, 1'b1, 50, 50));
      apply(pp(1, 50, 50, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(1, 50, 50, 1'b0, 1'b1, 12'h000));
      show = 1'b0;
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(1, 50, 50, 1'b0, 1'b0, 12'h000));
      show = 1'b1;
      apply(pp(1, 50, 50, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(1, 50, 50, 1'b0, 1'b1, 12'h000));
      show = 1'b0;
      apply(pp(1, 50, 50, 1'b0, 1'b1, 12'h000));
      show = 1'b1;
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL hide (%0d,%0d) dut%0d: got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.sel, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      repeat (3) apply(pp(0, 50, 50, 1'b0, 1'b1, 12'h000));
      #2;
      n_checks++;
      if (on_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre dut0: got on=%b, want on=1", on_v[0]);
      end
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (on_v[i] !== 1'b0 || rgb_v[i] !== 12'h000) begin
            n_fail++;
            $display("FAIL async_drop dut%0d: got on=%b rgb=%h, want on=0 rgb=000", i, on_v[i], rgb_v[i]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (on_v[0] !== 1'b0 || rgb_v[0] !== 12'h000) begin
         n_fail++;
         $display("FAIL async_hold dut0: got on=%b rgb=%h, want on=0 rgb=000", on_v[0], rgb_v[0]);
      end
      reset_n = 1'b1;
      sb.delete();
      apply(ev(1'b0, 1'b1, 50, 50));
      apply(pp(0, 50, 50, 1'b0, 1'b0, 12'h000));
      apply(pp(0, 50, 50, 1'b0, 1'b0, 12'h000));
      apply(ev(1'b1, 1'b0, 0, 0));
      apply(pp(0, 50, 50, 1'b0, 1'b1, 12'h000));
      apply(pp(0, 53, 57, 1'b0, 1'b1, 12'hFFF));
      flush();
      while (done.size() > 0) begin
         e = done.pop_front();
         n_checks++;
         if ({e.got_on, e.got_rgb} !== {e.on, e.rgb}) begin
            n_fail++;
            $display("FAIL async_resume (%0d,%0d): got on=%b rgb=%h, want on=%b rgb=%h",
                     e.x, e.y, e.got_on, e.got_rgb, e.on, e.rgb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shape();
      test_buffering();
      test_clip();
      test_scale();
      test_hide();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mouse_cursor_sprite.md
# mouse_cursor_sprite

Pixel-rate mouse-cursor renderer for the VGA mouse path. It sits between the VGA sync generator's pixel counters and the final colour mux. It generates the arrow-cursor bitmap procedurally for any cursor size and integer scale. Mouse position is double-buffered so that updates take effect only at frame start, which keeps the cursor tear-free. The block also applies an auto-hide timeout and a pressed-button colour, and drives a registered overlay enable plus RGB value.

## Interface
- COORD_W, 10: width of pixel and mouse coordinates.
- CUR_W, 8: bitmap width in bitmap pixels (1..16).
- CUR_H, 11: bitmap height in bitmap pixels (CUR_W..32).
- SCALE_LOG2, 0: each bitmap pixel is drawn 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels (0..2).
- RGB_W, 12: colour width.
- FILL_RGB, 12'hFFF: fill colour, button released.
- PRESS_RGB, 12'hF80: fill colour, left button held.
- OUTLINE_RGB, 12'h000: outline colour.
- HIDE_FRAMES, 180: frames without movement before auto-hide; 0 disables auto-hide.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_x  in  COORD_W  current pixel column.
- pix_y  in  COORD_W  current pixel row.
- video_on  in  1  active-video qualifier.
- frame_start  in  1  one-cycle pulse, first cycle of vertical blank.
- mouse_x  in  COORD_W  new cursor hotspot column.
- mouse_y  in  COORD_W  new cursor hotspot row.
- mouse_valid  in  1  one-cycle strobe; mouse_x/mouse_y are valid.
- btn_left  in  1  left button level.
- show  in  1  software cursor enable.
- cur_on  out  1  cursor pixel present.
- cur_rgb  out  RGB_W  cursor colour; 0 when cur_on=0.

## Operation
- Bitmap, procedural (no ROM). Row r holds n(r) set columns, counted from column 0 (hotspot at column 0, row 0).
  - n(r) = r+1 for r < CUR_W.
  - n(r) = CUR_H−r for r ≥ CUR_W, clamped to 0..CUR_W.
  - Defaults give 01,03,07,0F,1F,3F,7F,FF,07,03,01.
- Outline pixel: a set pixel with c=0, or c=n(r)−1, or r=0, or r=CUR_H−1. Every other set pixel is fill.
- Position buffering:
  - mouse_valid loads pend_x/pend_y.
  - frame_start copies pend into act_x/act_y.
  - If mouse_valid and frame_start coincide, act takes the old pend value, and the new sample lands in pend. The new sample is displayed one frame later.
- Hit test:
  - dx = pix_x − act_x and dy = pix_y − act_y, each computed COORD_W+1 bits wide and signed.
  - Hit when 0 ≤ dx < CUR_W<<SCALE_LOG2 and 0 ≤ dy < CUR_H<<SCALE_LOG2.
  - Bitmap coordinates: c = dx>>SCALE_LOG2, r = dy>>SCALE_LOG2.
  - A cursor that extends past the right or bottom edge is simply clipped; there is no wrap-around.
- Idle counter:
  - Cleared on mouse_valid.
  - Otherwise incremented on each frame_start, saturating at HIDE_FRAMES.
  - If mouse_valid and frame_start coincide, clear wins.
- Visibility: at each frame_start, act_vis ← show && (HIDE_FRAMES==0 || idle_cnt < HIDE_FRAMES), evaluated with the counter value before the update. act_vis is constant for the whole frame.
- Colour:
  - OUTLINE_RGB for an outline pixel.
  - Otherwise PRESS_RGB if btn_left, else FILL_RGB. btn_left is sampled in stage 1.
- Output: cur_on = video_on && act_vis && hit && bit set.

## Timing
- Two-stage pipeline. Latency from pix_x/pix_y/video_on to cur_on/cur_rgb is 2 clocks. The sync generator delays hsync/vsync by 2 to match.
  - Stage 1 registers dx, dy, range flags, video_on and btn_left.
  - Stage 2 registers the bitmap lookup, cur_on and cur_rgb.
- Throughput: one pixel per clock, with no stall.
- Reset (asynchronous, reset_n=0):
  - pend, act, idle_cnt, act_vis and all pipeline registers go to 0.
  - cur_on=0 and cur_rgb=0 within the reset, and they stay 0 until the first frame_start with show=1 has passed.
- Reset asserted mid-frame forces the outputs to 0 immediately. Drawing resumes only after the next frame_start.
- mouse_valid and show have no effect on the current frame's image.

## Test plan
- Reset, show=1, mouse (100,50) before a frame_start, SCALE_LOG2=0:
  - Pixel (100,50) gives cur_on=1, cur_rgb=000 (outline), 2 clocks after it is presented.
  - (103,57) gives cur_on=1, cur_rgb=FFF (fill).
  - (108,57) gives cur_on=0.
  - (100,60) gives cur_on=1; (101,60) gives cur_on=0.
- Position buffering:
  - mouse_valid to (200,200) mid-frame: the cursor stays at (100,50) until the next frame_start and moves only after it.
  - mouse_valid coincident with frame_start: the move is delayed one extra frame.
- Mouse at (636,475) on 640×480: columns 636..639 and rows 475..479 are drawn, with no artefacts at x=0 or y=0.
- HIDE_FRAMES=3, no mouse_valid:
  - Visible for frames 1..3, then cur_on=0.
  - One mouse_valid restores visibility at the next frame.
- SCALE_LOG2=1, btn_left=1, cursor at (10,10):
  - (14,24) gives cur_on=1, cur_rgb=F80 (bitmap r=7, c=2, fill).
  - (10..11,10..11) gives OUTLINE_RGB.
- Apply reset_n=0 while cur_on=1: cur_on and cur_rgb drop to 0 asynchronously and stay 0 until a frame_start after reset release.
